vga_write_scheduler: RTL and testbench

Sequencer and arbiter for the sprite engine's register write port (wren/addr/ldr). It shares that port between two requesters, port 0 (CPU store path) and port 1 (input/motion unit). Bitmap writes may go out at any time. Sprite position writes are held back until the vertical sync window, so position changes never tear mid-frame. Every write is driven as a clean setup/strobe/hold pulse, because the sprite engine captures data on the rising edge of wren.

---
 rtl/vga_write_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_vga_write_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_write_scheduler.sv
// vga_write_scheduler
//   Arbitrates the sprite engine register write port between two requesters
//   (port 0: CPU store path, port 1: input/motion unit) and drives each write
//   as a setup / strobe / hold sequence so the engine sees a clean wren rise.
//   Position registers (0x20-0x23) are only written while the synchronized
//   vsync window is open. Addresses 0x24-0x3F are accepted and discarded.
//
//   Optional feature macro: VGA_WSCHED_ROUND_ROBIN_EN
//     defined   -> round-robin arbitration when both ports are eligible
//     undefined -> fixed priority, port 0 wins
module vga_write_scheduler #(
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic        clk_50Mhz,
    input  logic        reset,
    input  logic        vsync,
    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic [5:0]  p0_addr,
    input  logic [15:0] p0_data,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic [5:0]  p1_addr,
    input  logic [15:0] p1_data,
    output logic        wren,
    output logic [5:0]  addr,
    output logic [15:0] ldr,
    output logic        window,
    output logic        busy,
    output logic        drop
);

    localparam int unsigned CNT_W = $clog2(STROBE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         addr_q, addr_d;
    logic [15:0]        ldr_q, ldr_d;
    logic               wren_q, wren_d;
    logic               drop_q, drop_d;
    logic               sync1_q, window_q;

    logic               p0_elig, p1_elig;
    logic               grant0, grant1;
    logic               idle;
    logic               accept;
    logic [5:0]         sel_addr;
    logic [15:0]        sel_data;

    // Position registers live at 0x20-0x23.
    function automatic logic is_position(input logic [5:0] a);
        return a[5:2] == 4'b1000;
    endfunction

    // Anything at or above 0x20 that is not a position register is illegal.
    function automatic logic is_illegal(input logic [5:0] a);
        return a[5] && !is_position(a);
    endfunction

    // Eligibility: bitmap and illegal addresses always, position only in window.
    always_comb begin
        p0_elig = p0_valid && (!is_position(p0_addr) || window_q);
        p1_elig = p1_valid && (!is_position(p1_addr) || window_q);
    end

`ifdef VGA_WSCHED_ROUND_ROBIN_EN
    // prio_q = 1 means port 1 wins the next tie; it points away from the last grant.
    logic prio_q, prio_d;

    // Round-robin tie break between two eligible ports.
    always_comb begin
        grant1 = p1_elig && (!p0_elig || prio_q);
        grant0 = p0_elig && !grant1;
        prio_d = accept ? p0_ready : prio_q;
    end

    // Round-robin pointer register; updated on every accept, dropped ones included.
    always_ff @(posedge clk_50Mhz or posedge reset) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    // Fixed priority: port 0 always wins a tie.
    always_comb begin
        grant0 = p0_elig;
        grant1 = p1_elig && !p0_elig;
    end
`endif

    // Readys are only offered in IDLE and are forced low while reset is held.
    always_comb begin
        idle     = (state_q == S_IDLE);
        p0_ready = idle && !reset && grant0;
        p1_ready = idle && !reset && grant1;
        accept   = p0_ready || p1_ready;
        sel_addr = p1_ready ? p1_addr : p0_addr;
        sel_data = p1_ready ? p1_data : p0_data;
    end

    // Write sequencer next-state logic: IDLE -> SETUP -> STROBE(xN) -> HOLD -> IDLE.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        ldr_d   = ldr_q;
        drop_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_illegal(sel_addr)) begin
                        drop_d = 1'b1;
                    end else begin
                        addr_d  = sel_addr;
                        ldr_d   = sel_data;
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                cnt_d   = CNT_W'(STROBE_CYCLES);
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        wren_d = (state_d == S_STROBE);
    end

    // Sequencer state, datapath and registered strobe.
    always_ff @(posedge clk_50Mhz or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            ldr_q   <= '0;
            wren_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ldr_q   <= ldr_d;
            wren_q  <= wren_d;
            drop_q  <= drop_d;
        end
    end

    // Two-flop synchronizer bringing vsync into this clock domain.
    always_ff @(posedge clk_50Mhz or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            window_q <= 1'b0;
        end else begin
            sync1_q  <= vsync;
            window_q <= sync1_q;
        end
    end

    assign wren   = wren_q;
    assign addr   = addr_q;
    assign ldr    = ldr_q;
    assign window = window_q;
    assign busy   = !idle;
    assign drop   = drop_q;

endmodule

// File: tb/tb_vga_write_scheduler.sv
// Testbench for vga_write_scheduler (STROBE_CYCLES = 2).
// Per-cycle vector table plus a hand-written reset-during-strobe sequence.
// Expectations follow VGA_WSCHED_ROUND_ROBIN_EN when the bench is built with it.
module tb_vga_write_scheduler;

`ifdef VGA_WSCHED_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        vsync;
    logic        p0_valid, p1_valid;
    logic        p0_ready, p1_ready;
    logic [5:0]  p0_addr, p1_addr;
    logic [15:0] p0_data, p1_data;
    logic        wren, window, busy, drop;
    logic [5:0]  addr;
    logic [15:0] ldr;

    int n_checks = 0;
    int n_fail   = 0;

    vga_write_scheduler #(.STROBE_CYCLES(2)) dut (
        .clk_50Mhz (clk),
        .reset     (reset),
        .vsync     (vsync),
        .p0_valid  (p0_valid),
        .p0_ready  (p0_ready),
        .p0_addr   (p0_addr),
        .p0_data   (p0_data),
        .p1_valid  (p1_valid),
        .p1_ready  (p1_ready),
        .p1_addr   (p1_addr),
        .p1_data   (p1_data),
        .wren      (wren),
        .addr      (addr),
        .ldr       (ldr),
        .window    (window),
        .busy      (busy),
        .drop      (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record = inputs held for one clock cycle and outputs expected in that cycle.
    typedef struct {
        logic        p0v;
        logic [5:0]  p0a;
        logic [15:0] p0d;
        logic        p1v;
        logic [5:0]  p1a;
        logic [15:0] p1d;
        logic        vs;
        logic        r0, r1, wr, bz, dr, win;
        logic [5:0]  ea;
        logic [15:0] el;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic p0v, input logic [5:0] p0a, input logic [15:0] p0d,
                       input logic p1v, input logic [5:0] p1a, input logic [15:0] p1d,
                       input logic vs, input logic r0, input logic r1, input logic wr,
                       input logic bz, input logic dr, input logic win,
                       input logic [5:0] ea, input logic [15:0] el);
        vec_t v;
        v.p0v = p0v; v.p0a = p0a; v.p0d = p0d;
        v.p1v = p1v; v.p1a = p1a; v.p1d = p1d;
        v.vs  = vs;  v.r0 = r0;  v.r1 = r1;  v.wr = wr;
        v.bz  = bz;  v.dr = dr;  v.win = win; v.ea = ea; v.el = el;
        vecs.push_back(v);
    endtask

    // Cycle with no requests: readys are expected low.
    task automatic nr(input logic vs, input logic wr, input logic bz, input logic dr,
                      input logic win, input logic [5:0] ea, input logic [15:0] el);
        add(0, 6'h00, 16'h0000, 0, 6'h00, 16'h0000, vs, 0, 0, wr, bz, dr, win, ea, el);
    endtask

    task automatic drive(input logic p0v, input logic [5:0] p0a, input logic [15:0] p0d,
                         input logic p1v, input logic [5:0] p1a, input logic [15:0] p1d,
                         input logic vs);
        p0_valid = p0v; p0_addr = p0a; p0_data = p0d;
        p1_valid = p1v; p1_addr = p1a; p1_data = p1d;
        vsync    = vs;
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, " p0_ready"}, p0_ready, v.r0);
        check({tag, " p1_ready"}, p1_ready, v.r1);
        check({tag, " wren"},     wren,     v.wr);
        check({tag, " busy"},     busy,     v.bz);
        check({tag, " drop"},     drop,     v.dr);
        check({tag, " window"},   window,   v.win);
        check({tag, " addr"},     addr,     v.ea);
        check({tag, " ldr"},      ldr,      v.el);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  d2a, fa, ga;
        logic [15:0] d2l, fl, gl;
        vec_t        rv;
        bit          seen;
        int          wcount;

        d2a = RR ? 6'h02 : 6'h01;  d2l = RR ? 16'h0002 : 16'h0001;
        fa  = RR ? 6'h1F : 6'h00;  fl  = RR ? 16'h00BB : 16'h00AA;
        ga  = RR ? 6'h23 : 6'h0A;  gl  = RR ? 16'h0023 : 16'h000A;

        // A: port 0 bitmap write, busy 4 cycles, wren 2 cycles
        add(1, 6'h05, 16'hA5A5, 0, 6'h00, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 6'h00, 16'h0000);
        nr(0, 0, 1, 0, 0, 6'h05, 16'hA5A5);
        nr(0, 1, 1, 0, 0, 6'h05, 16'hA5A5);
        nr(0, 1, 1, 0, 0, 6'h05, 16'hA5A5);
        nr(0, 0, 1, 0, 0, 6'h05, 16'hA5A5);
        nr(0, 0, 0, 0, 0, 6'h05, 16'hA5A5);
        // B: port 1 position write waits for the window (2-clock sync lag)
        add(0, 6'h00, 16'h0000, 1, 6'h20, 16'h0140, 0, 0, 0, 0, 0, 0, 0, 6'h05, 16'hA5A5);
        add(0, 6'h00, 16'h0000, 1, 6'h20, 16'h0140, 1, 0, 0, 0, 0, 0, 0, 6'h05, 16'hA5A5);
        add(0, 6'h00, 16'h0000, 1, 6'h20, 16'h0140, 1, 0, 0, 0, 0, 0, 0, 6'h05, 16'hA5A5);
        add(0, 6'h00, 16'h0000, 1, 6'h20, 16'h0140, 1, 0, 1, 0, 0, 0, 1, 6'h05, 16'hA5A5);
        nr(0, 0, 1, 0, 1, 6'h20, 16'h0140);
        nr(0, 1, 1, 0, 1, 6'h20, 16'h0140);
        nr(0, 1, 1, 0, 0, 6'h20, 16'h0140);
        nr(0, 0, 1, 0, 0, 6'h20, 16'h0140);
        nr(0, 0, 0, 0, 0, 6'h20, 16'h0140);
        // C: blocked position write on port 1 does not stall port 0
        add(1, 6'h11, 16'h1111, 1, 6'h21, 16'h0033, 0, 1, 0, 0, 0, 0, 0, 6'h20, 16'h0140);
        add(0, 6'h00, 16'h0000, 1, 6'h21, 16'h0033, 1, 0, 0, 0, 1, 0, 0, 6'h11, 16'h1111);
        add(0, 6'h00, 16'h0000, 1, 6'h21, 16'h0033, 1, 0, 0, 1, 1, 0, 0, 6'h11, 16'h1111);
        add(0, 6'h00, 16'h0000, 1, 6'h21, 16'h0033, 1, 0, 0, 1, 1, 0, 1, 6'h11, 16'h1111);
        add(0, 6'h00, 16'h0000, 1, 6'h21, 16'h0033, 1, 0, 0, 0, 1, 0, 1, 6'h11, 16'h1111);
        add(0, 6'h00, 16'h0000, 1, 6'h21, 16'h0033, 1, 0, 1, 0, 0, 0, 1, 6'h11, 16'h1111);
        nr(1, 0, 1, 0, 1, 6'h21, 16'h0033);
        nr(1, 1, 1, 0, 1, 6'h21, 16'h0033);
        nr(1, 1, 1, 0, 1, 6'h21, 16'h0033);
        nr(1, 0, 1, 0, 1, 6'h21, 16'h0033);
        nr(1, 0, 0, 0, 1, 6'h21, 16'h0033);
        // D: both ports stream bitmap writes
        add(1, 6'h01, 16'h0001, 1, 6'h02, 16'h0002, 1, 1, 0, 0, 0, 0, 1, 6'h21, 16'h0033);
        add(1, 6'h01, 16'h0001, 1, 6'h02, 16'h0002, 1, 0, 0, 0, 1, 0, 1, 6'h01, 16'h0001);
        add(1, 6'h01, 16'h0001, 1, 6'h02, 16'h0002, 1, 0, 0, 1, 1, 0, 1, 6'h01, 16'h0001);
        add(1, 6'h01, 16'h0001, 1, 6'h02, 16'h0002, 1, 0, 0, 1, 1, 0, 1, 6'h01, 16'h0001);
        add(1, 6'h01, 16'h0001, 1, 6'h02, 16'h0002, 1, 0, 0, 0, 1, 0, 1, 6'h01, 16'h0001);
        add(1, 6'h01, 16'h0001, 1, 6'h02, 16'h0002, 1, !RR, RR, 0, 0, 0, 1, 6'h01, 16'h0001);
        add(1, 6'h01, 16'h0001, 1, 6'h02, 16'h0002, 1, 0, 0, 0, 1, 0, 1, d2a, d2l);
        add(1, 6'h01, 16'h0001, 1, 6'h02, 16'h0002, 1, 0, 0, 1, 1, 0, 1, d2a, d2l);
        add(1, 6'h01, 16'h0001, 1, 6'h02, 16'h0002, 1, 0, 0, 1, 1, 0, 1, d2a, d2l);
        add(1, 6'h01, 16'h0001, 1, 6'h02, 16'h0002, 1, 0, 0, 0, 1, 0, 1, d2a, d2l);
        add(1, 6'h01, 16'h0001, 1, 6'h02, 16'h0002, 1, 1, 0, 0, 0, 0, 1, d2a, d2l);
        nr(1, 0, 1, 0, 1, 6'h01, 16'h0001);
        nr(1, 1, 1, 0, 1, 6'h01, 16'h0001);
        nr(1, 1, 1, 0, 1, 6'h01, 16'h0001);
        nr(1, 0, 1, 0, 1, 6'h01, 16'h0001);
        // E: illegal address 0x30 is accepted and dropped, addr/ldr untouched
        add(1, 6'h30, 16'hBEEF, 0, 6'h00, 16'h0000, 1, 1, 0, 0, 0, 0, 1, 6'h01, 16'h0001);
        nr(1, 0, 0, 1, 1, 6'h01, 16'h0001);
        nr(1, 0, 0, 0, 1, 6'h01, 16'h0001);
        // Boundaries 0x00 / 0x1F (bitmap) against each other
        add(1, 6'h00, 16'h00AA, 1, 6'h1F, 16'h00BB, 1, !RR, RR, 0, 0, 0, 1, 6'h01, 16'h0001);
        nr(1, 0, 1, 0, 1, fa, fl);
        nr(1, 1, 1, 0, 1, fa, fl);
        nr(1, 1, 1, 0, 1, fa, fl);
        nr(1, 0, 1, 0, 1, fa, fl);
        // 0x24 is the first illegal address; its accept still moves the pointer
        add(1, 6'h24, 16'h1234, 0, 6'h00, 16'h0000, 1, 1, 0, 0, 0, 0, 1, fa, fl);
        nr(1, 0, 0, 1, 1, fa, fl);
        // 0x23 (last position register) against a bitmap write on port 0
        add(1, 6'h0A, 16'h000A, 1, 6'h23, 16'h0023, 1, !RR, RR, 0, 0, 0, 1, fa, fl);
        nr(1, 0, 1, 0, 1, ga, gl);
        nr(1, 1, 1, 0, 1, ga, gl);
        nr(1, 1, 1, 0, 1, ga, gl);
        nr(1, 0, 1, 0, 1, ga, gl);
        nr(1, 0, 0, 0, 1, ga, gl);

        // Reset state
        reset = 1'b1;
        drive(0, 6'h00, 16'h0000, 0, 6'h00, 16'h0000, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rv = '{p0v: 0, p0a: 0, p0d: 0, p1v: 0, p1a: 0, p1d: 0, vs: 0,
               r0: 0, r1: 0, wr: 0, bz: 0, dr: 0, win: 0, ea: 6'h00, el: 16'h0000};
        check_outputs("reset", rv);
        @(posedge clk);
        #1 reset = 1'b0;

        // Table-driven cycles
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].p0v, vecs[i].p0a, vecs[i].p0d,
                  vecs[i].p1v, vecs[i].p1a, vecs[i].p1d, vecs[i].vs);
            @(negedge clk);
            check_outputs($sformatf("vec%0d", i), vecs[i]);
            @(posedge clk);
            #1;
        end

        // Reset asserted during STROBE
        drive(1, 6'h07, 16'h7777, 0, 6'h00, 16'h0000, 0);
        @(negedge clk);
        check("rst_seq accept p0_ready", p0_ready, 1'b1);
        @(posedge clk);
        #1 drive(0, 6'h00, 16'h0000, 0, 6'h00, 16'h0000, 0);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (wren) seen = 1'b1;
        end
        check("rst_seq wren_rise_timeout", seen, 1'b1);
        #1;
        drive(1, 6'h07, 16'h7777, 1, 6'h08, 16'h8888, 0);
        reset = 1'b1;
        #1;
        check("rst_mid wren",     wren,     1'b0);
        check("rst_mid busy",     busy,     1'b0);
        check("rst_mid p0_ready", p0_ready, 1'b0);
        check("rst_mid p1_ready", p1_ready, 1'b0);
        check("rst_mid addr",     addr,     6'h00);
        check("rst_mid ldr",      ldr,      16'h0000);
        check("rst_mid window",   window,   1'b0);
        check("rst_mid drop",     drop,     1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst p0_ready", p0_ready, 1'b1);
        check("post_rst p1_ready", p1_ready, 1'b0);
        @(posedge clk);
        #1 drive(0, 6'h00, 16'h0000, 0, 6'h00, 16'h0000, 0);
        @(negedge clk);
        check("post_rst setup busy", busy, 1'b1);
        check("post_rst setup wren", wren, 1'b0);
        check("post_rst setup addr", addr, 6'h07);
        check("post_rst setup ldr",  ldr,  16'h7777);
        wcount = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (wren) wcount++;
        end
        check("post_rst wren cycles", 16'(wcount), 16'd2);
        check("post_rst final busy",  busy, 1'b0);
        check("post_rst final addr",  addr, 6'h07);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
